seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Programmable serial bit-pattern detector; the parametrised successor of the fixed 4-bit "1101" Mealy detector. Pattern (up to MAX_LEN bits), active length and overlap mode are run-time configurable, input is qualified by a valid strobe, and a saturating match counter is kept. It sits on a serial data path between the bit-serialiser and the control/status logic that consumes match pulses and counts.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits (2..32).
- LEN_W, default $clog2(MAX_LEN)+1: width of the pattern-length field.
- CNT_W, default 8: width of the match counter.
- RST_PAT, default 8'b0000_1101: pattern loaded at reset.
- RST_LEN, default 4: pattern length loaded at reset.
- RST_OVL, default 1: overlap mode loaded at reset.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din sampled only when high.
- cfg_load  in  1  one-cycle strobe: load cfg_pattern, cfg_len, cfg_overlap.
- cfg_pattern  in  MAX_LEN  new pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  new active length, legal 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr  in  1  clear match counter.
- match  out  1  registered one-cycle pulse per detected pattern.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  one-cycle pulse when a cfg_load carried an illegal length.

## Operation
- State: history shift register hist[MAX_LEN-1:0] (hist[0] newest bit), fill counter fill (0..MAX_LEN, saturating), config registers pat, len, ovl.
- On an accepted beat (din_valid=1, cfg_load=0): hist_n = {hist[MAX_LEN-2:0], din}; fill_n = min(fill+1, MAX_LEN).
- Hit condition on that beat: fill_n >= len and hist_n[len-1:0] == pat[len-1:0] (bits above len ignored).
- On hit: match <= 1, counter increments; if ovl=0, fill <= 0 (matching bits cannot be reused); if ovl=1, fill <= fill_n.
- No accepted beat: hist, fill hold; match <= 0.
- cfg_load=1 with 1 <= cfg_len <= MAX_LEN: pat, len, ovl updated; hist and fill cleared; din on that cycle discarded; match <= 0; match_count unaffected.
- cfg_load=1 with cfg_len = 0 or > MAX_LEN: config, hist, fill unchanged; din on that cycle discarded; cfg_err <= 1 for one cycle.
- Counter: saturates at 2^CNT_W-1. cnt_clr alone -> 0. cnt_clr with a hit in the same cycle -> 1 (match never lost).
- Equivalent legacy behaviour: reset configuration (1101, len 4, overlap) reproduces the fixed detector with din_valid tied high.

## Timing
- Reset (rst=1): match=0, match_count=0, cfg_err=0, hist=0, fill=0, pat=RST_PAT, len=RST_LEN, ovl=RST_OVL. rst has priority over all inputs; reset mid-pattern discards partial history.
- Match latency: match high exactly one cycle after the clock edge that samples the final pattern bit; match_count updated on the same edge as match.
- Back-to-back matches possible on consecutive accepted beats (e.g. pattern "11", len 2, overlap).
- din_valid gaps do not break a partial match; only accepted beats shift history.
- cfg_err latency: one cycle after the cfg_load edge.
- New configuration is active for the first accepted beat after the cfg_load cycle.

## Test plan
- Reset defaults, din_valid=1, stream 1,1,0,1,1,0,1 -> match pulses after 4th and 7th bits (overlap), match_count=2.
- cfg_load pattern 8'b1011_0110? no: pattern "1010", len 4, overlap=0; stream 1,0,1,0,1,0 -> single match after 4th bit, count=1; repeat with overlap=1 -> matches after 4th and 6th bits, count=2.
- Gapped input: reset config, din 1,1,0,1 with din_valid low for 3 cycles between each bit -> exactly one match, one cycle after final valid bit.
- Full length: len=MAX_LEN=8, pattern 8'hA5, stream 1010_0101 -> match after 8th bit only; first 7 bits never match even if pattern suffix aligns.
- Illegal config: cfg_load with cfg_len=0 then 9 -> cfg_err pulses twice, subsequent 1101 stream still detected with reset config.
- Counter: CNT_W=2, pattern "1" len 1, 5 consecutive ones -> count 1,2,3,3,3; assert cnt_clr on a hit cycle -> count=1; rst during partial "110" -> no match on following "1".

Source files
------------

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-pattern detector.
// Keeps a shift register of the most recent accepted bits and compares the
// newest 'len' of them against a run-time loadable pattern. Matches are
// reported as a registered one-cycle pulse and accumulated in a saturating
// counter. Loading a configuration restarts detection from an empty history.
module seq_detect_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1101),
    parameter int                 RST_LEN = 4,
    parameter bit                 RST_OVL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bit history (hist[0] is the newest bit) and how many valid bits it holds
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;

    // Active configuration
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    // Per-cycle decode
    logic [MAX_LEN-1:0] mask;
    logic               accept;
    logic               cfg_ok;
    logic               hit;

    // Decode the beat: shifted history, saturated fill, and the hit test on the low 'len' bits
    always_comb begin
        accept = din_valid & ~cfg_load;
        cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_L);
        hist_n = {hist[MAX_LEN-2:0], din};
        fill_n = (fill >= MAX_L) ? MAX_L : fill + 1'b1;
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = accept && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
    end

    // History, fill and configuration registers; a legal load clears history, an illegal one changes nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= RST_PAT;
            len  <= LEN_W'(RST_LEN);
            ovl  <= RST_OVL;
        end else if (cfg_load) begin
            if (cfg_ok) begin
                pat  <= cfg_pattern;
                len  <= cfg_len;
                ovl  <= cfg_overlap;
                hist <= '0;
                fill <= '0;
            end
        end else if (accept) begin
            hist <= hist_n;
            fill <= (hit && !ovl) ? '0 : fill_n;
        end
    end

    // Registered status pulses: match for a hit, cfg_err for a load with an out-of-range length
    always_ff @(posedge clk) begin
        if (rst) begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_load & ~cfg_ok;
        end
    end

    // Saturating match counter; a clear coinciding with a hit leaves that hit counted
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= hit ? CNT_W'(1) : '0;
        end else if (hit && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed-vector bench for seq_detect_prog.
// The counter is narrowed to 2 bits so saturation is reachable quickly.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    int vecCount  = 0;
    int missCount = 0;

    seq_detect_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .match_count(match_count),
        .cfg_err    (cfg_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data cycle; match is checked right after the sampling edge
    task automatic applyStimulus(input logic d, input logic v, input logic expMatch, input string tag);
        din       = d;
        din_valid = v;
        tick();
        din_valid = 1'b0;
        checkOutput(tag, {31'd0, match}, {31'd0, expMatch});
    endtask

    // Synchronous reset for one cycle
    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One cfg_load cycle with din_valid high to confirm that din is discarded
    task automatic loadConfig(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                              input logic o, input logic expErr, input string tag);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        din         = 1'b1;
        din_valid   = 1'b1;
        tick();
        cfg_load  = 1'b0;
        din_valid = 1'b0;
        checkOutput({tag, "_err"}, {31'd0, cfg_err}, {31'd0, expErr});
        checkOutput({tag, "_match"}, {31'd0, match}, 32'd0);
    endtask

    // Feed a bit string (MSB first) with din_valid high and check match per beat
    task automatic runStream(input logic [15:0] bits, input logic [15:0] expm, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, expm[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    initial begin
        // Reset defaults
        doReset();
        checkOutput("rst_match", {31'd0, match}, 32'd0);
        checkOutput("rst_count", {30'd0, match_count}, 32'd0);
        checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);

        // Legacy 1101 overlapping: stream 1101101
        runStream(16'b1101101, 16'b0001001, 7, "legacy");
        checkOutput("legacy_count", {30'd0, match_count}, 32'd2);

        // Pattern 1010, non-overlapping: stream 101010
        doReset();
        loadConfig(8'b0000_1010, 4'd4, 1'b0, 1'b0, "ld1010n");
        runStream(16'b101010, 16'b000100, 6, "novl");
        checkOutput("novl_count", {30'd0, match_count}, 32'd1);

        // Pattern 1010, overlapping
        doReset();
        loadConfig(8'b0000_1010, 4'd4, 1'b1, 1'b0, "ld1010o");
        runStream(16'b101010, 16'b000101, 6, "ovl");
        checkOutput("ovl_count", {30'd0, match_count}, 32'd2);

        // Gapped 1101 with three invalid cycles carrying the opposite bit
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, "gap_v1");
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b0, "gap_i1");
        applyStimulus(1'b1, 1'b1, 1'b0, "gap_v2");
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b0, "gap_i2");
        applyStimulus(1'b0, 1'b1, 1'b0, "gap_v3");
        for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b0, "gap_i3");
        applyStimulus(1'b1, 1'b1, 1'b1, "gap_v4");
        applyStimulus(1'b1, 1'b0, 1'b0, "gap_after");
        checkOutput("gap_count", {30'd0, match_count}, 32'd1);

        // Full-length pattern A5
        doReset();
        loadConfig(8'hA5, 4'd8, 1'b1, 1'b0, "ldA5");
        runStream(16'b1010_0101, 16'b0000_0001, 8, "full");
        checkOutput("full_count", {30'd0, match_count}, 32'd1);

        // Illegal lengths leave the reset configuration in place
        doReset();
        loadConfig(8'hFF, 4'd0, 1'b0, 1'b1, "bad0");
        applyStimulus(1'b0, 1'b0, 1'b0, "bad0_idle");
        checkOutput("bad0_errgone", {31'd0, cfg_err}, 32'd0);
        loadConfig(8'hFF, 4'd9, 1'b0, 1'b1, "bad9");
        runStream(16'b1101, 16'b0001, 4, "postbad");
        checkOutput("postbad_err", {31'd0, cfg_err}, 32'd0);
        checkOutput("postbad_count", {30'd0, match_count}, 32'd1);

        // Saturating counter with pattern "1"; back-to-back matches
        doReset();
        loadConfig(8'h01, 4'd1, 1'b1, 1'b0, "ld1");
        applyStimulus(1'b1, 1'b1, 1'b1, "sat_b1");
        checkOutput("sat_c1", {30'd0, match_count}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, "sat_b2");
        checkOutput("sat_c2", {30'd0, match_count}, 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, "sat_b3");
        checkOutput("sat_c3", {30'd0, match_count}, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, "sat_b4");
        checkOutput("sat_c4", {30'd0, match_count}, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, "sat_b5");
        checkOutput("sat_c5", {30'd0, match_count}, 32'd3);

        // Clear coinciding with a hit keeps that hit; clear alone zeroes
        cnt_clr = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, "clrhit_m");
        checkOutput("clrhit_count", {30'd0, match_count}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, "clr_m");
        cnt_clr = 1'b0;
        checkOutput("clr_count", {30'd0, match_count}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, "zero_nomatch");

        // Reset mid-pattern discards the partial 110
        doReset();
        runStream(16'b110, 16'b000, 3, "part");
        doReset();
        checkOutput("midrst_count", {30'd0, match_count}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, "midrst_b");
        runStream(16'b101, 16'b001, 3, "midrst_rest");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
